// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU (alu_mc) and its iterative engine.
// Holds the opcode encoding, the FSM state encoding, the engine operation selector
// and the default operand width.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 16;

    // Opcode encoding; 4'b1010 and 4'b1100..4'b1111 are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_NOT  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SHL  = 4'b0110,
        OP_SHR  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIV  = 4'b1001,
        OP_SQRT = 4'b1011
    } alu_op_e;

    // Top-level handshake FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // Operation selector for the iterative engine.
    typedef enum logic [1:0] {
        ITER_MUL  = 2'b00,
        ITER_DIV  = 2'b01,
        ITER_SQRT = 2'b10
    } iter_kind_e;

endpackage : alu_pkg

// File: rtl/alu_iter.sv
// Iterative engine: unsigned shift-add multiply, restoring divide and (optionally)
// integer square root, one result bit per clock.
// Optional feature macro: ALU_MC_SQRT_EN compiles in the square-root datapath.
//
// Register roles per operation:
//   MUL : hi = partial product high half, lo = multiplier / product low half, aux = multiplicand
//   DIV : hi = partial remainder,         lo = dividend / quotient,           aux = divisor
//   SQRT: hi = partial remainder,         lo = root,                          aux = radicand (shifted out 2 bits/step)
// done_o is raised in the cycle whose clock edge performs the last step; result_o
// and result_x_o then show the values that step produces, so the caller can latch
// them on that same edge.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  iter_kind_e       kind_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_x_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] aux_q, aux_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    iter_kind_e       kind_q, kind_d;

    // Multiply step: conditionally add the multiplicand, then shift {carry,hi,lo} right.
    logic [WIDTH:0]   mul_sum_s;
    assign mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, aux_q} : {(WIDTH+1){1'b0}});

    // Divide step: bring down the next dividend bit and try subtracting the divisor.
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;
    assign div_shift_s = {hi_q, lo_q[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, aux_q};

`ifdef ALU_MC_SQRT_EN
    // Square-root step: bring down two radicand bits and compare against 4*root+1.
    logic [WIDTH+1:0] sq_rem_s;
    logic [WIDTH+1:0] sq_trial_s;
    logic [WIDTH-1:0] sq_diff_s;
    assign sq_rem_s   = {hi_q, aux_q[WIDTH-1:WIDTH-2]};
    assign sq_trial_s = {lo_q, 2'b01};
    assign sq_diff_s  = sq_rem_s[WIDTH-1:0] - sq_trial_s[WIDTH-1:0];
`endif

    // Next-state: load on start, otherwise perform one step while the counter runs.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        aux_d  = aux_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        if (start_i) begin
            kind_d = kind_i;
            hi_d   = {WIDTH{1'b0}};
            case (kind_i)
                ITER_MUL: begin
                    lo_d  = a_i;
                    aux_d = b_i;
                    cnt_d = CW'(WIDTH);
                end
                ITER_DIV: begin
                    lo_d  = a_i;
                    aux_d = b_i;
                    cnt_d = CW'(WIDTH);
                end
`ifdef ALU_MC_SQRT_EN
                ITER_SQRT: begin
                    lo_d  = {WIDTH{1'b0}};
                    aux_d = a_i;
                    cnt_d = CW'(WIDTH / 2);
                end
`endif
                default: begin
                    lo_d  = {WIDTH{1'b0}};
                    aux_d = {WIDTH{1'b0}};
                    cnt_d = {CW{1'b0}};
                end
            endcase
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
            case (kind_q)
                ITER_MUL: begin
                    hi_d = mul_sum_s[WIDTH:1];
                    lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
                end
                ITER_DIV: begin
                    if (div_trial_s[WIDTH] == 1'b0) begin
                        hi_d = div_trial_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
`ifdef ALU_MC_SQRT_EN
                ITER_SQRT: begin
                    aux_d = {aux_q[WIDTH-3:0], 2'b00};
                    if (sq_rem_s >= sq_trial_s) begin
                        hi_d = sq_diff_s;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = sq_rem_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
`endif
                default: begin
                    cnt_d = {CW{1'b0}};
                end
            endcase
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Engine state registers; reset aborts any running operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            aux_q  <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            kind_q <= ITER_MUL;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            aux_q  <= aux_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
        end
    end

    assign done_o     = (cnt_q == CW'(1)) && !start_i;
    assign result_o   = lo_d;
    assign result_x_o = hi_d;

endmodule : alu_iter

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle operations are computed here; multiply, divide and square root
// run in the alu_iter engine.
// Optional feature macro: ALU_MC_SQRT_EN enables opcode 1011 (integer square root);
// without it 1011 is treated as an illegal opcode.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_X,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_x_q, result_x_d;
    logic             err_q, err_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             iter_start_s;
    iter_kind_e       iter_kind_s;
    logic             iter_done_s;
    logic [WIDTH-1:0] iter_result_s;
    logic [WIDTH-1:0] iter_result_x_s;

    alu_op_e          op_s;
    logic [SHW-1:0]   shamt_s;

    assign op_s    = alu_op_e'(control);
    assign shamt_s = B[SHW-1:0];

    alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (iter_start_s),
        .kind_i     (iter_kind_s),
        .a_i        (A),
        .b_i        (B),
        .done_o     (iter_done_s),
        .result_o   (iter_result_s),
        .result_x_o (iter_result_x_s)
    );

    // Next-state and output-register values for the handshake FSM.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        result_x_d   = result_x_q;
        err_d        = err_q;
        iter_start_s = 1'b0;
        iter_kind_s  = ITER_MUL;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    result_x_d = {WIDTH{1'b0}};
                    err_d      = 1'b0;
                    state_d    = ST_DONE;
                    case (op_s)
                        OP_ADD: result_d = A + B;
                        OP_SUB: result_d = A - B;
                        OP_AND: result_d = A & B;
                        OP_NOT: result_d = ~A;
                        OP_OR:  result_d = A | B;
                        OP_XOR: result_d = A ^ B;
                        OP_SHL: result_d = A << shamt_s;
                        OP_SHR: result_d = A >> shamt_s;
                        OP_MUL: begin
                            iter_start_s = 1'b1;
                            iter_kind_s  = ITER_MUL;
                            state_d      = ST_BUSY;
                        end
                        OP_DIV: begin
                            if (B == {WIDTH{1'b0}}) begin
                                // Divide by zero finishes immediately with a flagged result.
                                result_d   = {WIDTH{1'b1}};
                                result_x_d = A;
                                err_d      = 1'b1;
                            end else begin
                                iter_start_s = 1'b1;
                                iter_kind_s  = ITER_DIV;
                                state_d      = ST_BUSY;
                            end
                        end
`ifdef ALU_MC_SQRT_EN
                        OP_SQRT: begin
                            iter_start_s = 1'b1;
                            iter_kind_s  = ITER_SQRT;
                            state_d      = ST_BUSY;
                        end
`endif
                        default: begin
                            result_d = {WIDTH{1'b0}};
                            err_d    = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (iter_done_s) begin
                    result_d   = iter_result_s;
                    result_x_d = iter_result_x_s;
                    err_d      = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= {WIDTH{1'b0}};
            result_x_q  <= {WIDTH{1'b0}};
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_x_q  <= result_x_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_X  = result_x_q;
    assign err       = err_q;

endmodule : alu_mc

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  control;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] result_X;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_X  (result_X),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single cycle and count cycles until out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        A = a; B = b; control = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_consume", {63'd0, in_ready}, 64'd1);
        check("out_valid_after_consume", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic expect_res(input string tag, input int lat,
                              input logic [15:0] e_res, input logic [15:0] e_x,
                              input logic e_err, input int e_lat);
        check({tag, "_latency"}, 64'(lat), 64'(e_lat));
        check({tag, "_result"}, {48'd0, result}, {48'd0, e_res});
        check({tag, "_result_X"}, {48'd0, result_X}, {48'd0, e_x});
        check({tag, "_err"}, {63'd0, err}, {63'd0, e_err});
        consume();
    endtask

    initial begin
        int lat;
        logic saw;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'd0; B = 16'd0; control = 4'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {48'd0, result}, 64'd0);
        check("rst_result_X", {48'd0, result_X}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        // Single-cycle operations
        run_op(16'hFFFF, 16'h0001, OP_ADD, lat); expect_res("add_wrap", lat, 16'h0000, 16'h0000, 1'b0, 1);
        run_op(16'h0005, 16'h0007, OP_SUB, lat); expect_res("sub_wrap", lat, 16'hFFFE, 16'h0000, 1'b0, 1);
        run_op(16'hF0F0, 16'h3C3C, OP_AND, lat); expect_res("and", lat, 16'h3030, 16'h0000, 1'b0, 1);
        run_op(16'h1234, 16'hFFFF, OP_NOT, lat); expect_res("not", lat, 16'hEDCB, 16'h0000, 1'b0, 1);
        run_op(16'hF000, 16'h000F, OP_OR,  lat); expect_res("or", lat, 16'hF00F, 16'h0000, 1'b0, 1);
        run_op(16'hFF00, 16'h0FF0, OP_XOR, lat); expect_res("xor", lat, 16'hF0F0, 16'h0000, 1'b0, 1);
        run_op(16'h0001, 16'h0014, OP_SHL, lat); expect_res("shl_low_bits", lat, 16'h0010, 16'h0000, 1'b0, 1);
        run_op(16'h8000, 16'h0003, OP_SHR, lat); expect_res("shr", lat, 16'h1000, 16'h0000, 1'b0, 1);

        // Multiply
        run_op(16'h1234, 16'h0100, OP_MUL, lat); expect_res("mul", lat, 16'h3400, 16'h0012, 1'b0, 17);
        run_op(16'hFFFF, 16'hFFFF, OP_MUL, lat); expect_res("mul_max", lat, 16'h0001, 16'hFFFE, 1'b0, 17);

        // Divide and divide by zero
        run_op(16'd100, 16'd7, OP_DIV, lat); expect_res("div", lat, 16'd14, 16'd2, 1'b0, 17);
        run_op(16'd5, 16'd0, OP_DIV, lat);   expect_res("div_zero", lat, 16'hFFFF, 16'd5, 1'b1, 1);

        // Square root (illegal when the datapath is not built)
`ifdef ALU_MC_SQRT_EN
        run_op(16'd200, 16'd0, OP_SQRT, lat); expect_res("sqrt", lat, 16'd14, 16'd4, 1'b0, 9);
`else
        run_op(16'd200, 16'd0, OP_SQRT, lat); expect_res("sqrt_disabled", lat, 16'd0, 16'd0, 1'b1, 1);
`endif
        run_op(16'h1111, 16'h2222, 4'b1010, lat); expect_res("illegal_1010", lat, 16'd0, 16'd0, 1'b1, 1);
        run_op(16'h1111, 16'h2222, 4'b1111, lat); expect_res("illegal_1111", lat, 16'd0, 16'd0, 1'b1, 1);

        // Hold in DONE with out_ready low; an in_valid pulse there is ignored
        run_op(16'd100, 16'd7, OP_DIV, lat);
        check("hold_first_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2); A = 16'd1; B = 16'd1; control = OP_ADD;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_result", {48'd0, result}, 64'd14);
            check("hold_result_X", {48'd0, result_X}, 64'd2);
        end
        consume();
        @(posedge clk); #1;
        check("no_op_from_done_pulse", {63'd0, out_valid}, 64'd0);

        // in_valid pulse during BUSY is ignored
        @(negedge clk);
        A = 16'd3; B = 16'd5; control = OP_MUL; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        A = 16'd1; B = 16'd1; control = OP_ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; lat++;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        expect_res("mul_busy_pulse", lat, 16'd15, 16'd0, 1'b0, 17);

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        A = 16'd100; B = 16'd7; control = OP_DIV; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_result", {48'd0, result}, 64'd0);
        check("abort_result_X", {48'd0, result_X}, 64'd0);
        check("abort_err", {63'd0, err}, 64'd0);
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) saw = 1'b1;
        end
        check("abort_no_out_valid", {63'd0, saw}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_mc
